fb_write_scheduler: RTL and testbench

Arbitrates the single framebuffer write port among three sources: a full-screen clear engine (internal), the mouse cursor plotter and the line/shape drawer. Requesters present a pixel (x, y, color) with a request and hold it until granted. Each granted pixel appears on the registered framebuffer write port one cycle later. Out-of-range pixels are consumed but never written, so the VGA buffer is protected from stray coordinates.

---
 rtl/fb_pkg.sv | 22 ++
 rtl/fb_raster_counter.sv | 58 +++++
 rtl/fb_write_scheduler.sv | 164 ++++++++++++++++
 tb/tb_fb_write_scheduler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the framebuffer write path.
//   FB_CW / FB_WIDTH / FB_HEIGHT : default coordinate width and visible raster size
//   fb_state_e                   : write scheduler states (IDLE, CLEAR)
//   pixel_t                      : one pixel as presented by the mouse and drawer blocks
package fb_pkg;

   localparam int FB_CW     = 11;
   localparam int FB_WIDTH  = 640;
   localparam int FB_HEIGHT = 480;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } fb_state_e;

   typedef struct packed {
      logic [FB_CW-1:0] x;
      logic [FB_CW-1:0] y;
      logic             color;
   } pixel_t;

endpackage

// File: rtl/fb_raster_counter.sv
// fb_raster_counter: raster position generator for the clear sweep.
//   clk, reset         : clock, synchronous active-high reset
//   i_start            : force position to (0,0)
//   i_advance          : step to the next raster position
//   o_cx, o_cy         : current position
//   o_nx, o_ny         : position that i_advance would move to
//   o_last             : current position is (WIDTH-1, HEIGHT-1)
module fb_raster_counter
   import fb_pkg::*;
#(
   parameter int CW     = FB_CW,
   parameter int WIDTH  = FB_WIDTH,
   parameter int HEIGHT = FB_HEIGHT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_start,
   input  logic          i_advance,
   output logic [CW-1:0] o_cx,
   output logic [CW-1:0] o_cy,
   output logic [CW-1:0] o_nx,
   output logic [CW-1:0] o_ny,
   output logic          o_last
);

   localparam logic [CW-1:0] X_MAX = CW'(WIDTH - 1);
   localparam logic [CW-1:0] Y_MAX = CW'(HEIGHT - 1);

   logic [CW-1:0] r_cx;
   logic [CW-1:0] r_cy;
   logic          w_x_wrap;
   logic          w_y_wrap;

   always_comb begin
      w_x_wrap = (r_cx == X_MAX);
      w_y_wrap = (r_cy == Y_MAX);
      o_nx     = w_x_wrap ? '0 : r_cx + 1'b1;
      o_ny     = r_cy;
      if (w_x_wrap) begin
         o_ny = w_y_wrap ? '0 : r_cy + 1'b1;
      end
      o_last   = w_x_wrap && w_y_wrap;
   end

   always_ff @(posedge clk) begin
      if (reset || i_start) begin
         r_cx <= '0;
         r_cy <= '0;
      end else if (i_advance) begin
         r_cx <= o_nx;
         r_cy <= o_ny;
      end
   end

   assign o_cx = r_cx;
   assign o_cy = r_cy;

endmodule

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: arbitrates the single framebuffer write port between
// the internal clear sweep, the mouse plotter and the line/shape drawer.
//   clk, reset             : clock, synchronous active-high reset
//   clear_req / clear_busy : start a full-screen clear / sweep in progress
//                            (clear_busy is the FSM state: 1 = CLEAR)
//   m_req/m_x/m_y/m_color  : mouse pixel, held until m_gnt (combinational)
//   d_req/d_x/d_y/d_color  : drawer pixel, held until d_gnt (combinational)
//   fb_x/fb_y/fb_color/fb_we : registered write port, one cycle after grant
//   drop                   : registered pulse, granted pixel was out of range
// Handshake: a requester raises req with stable x/y/color; the pixel is
// consumed in the cycle its gnt is high and may change on the following cycle.
module fb_write_scheduler
   import fb_pkg::*;
#(
   parameter int WIDTH  = FB_WIDTH,
   parameter int HEIGHT = FB_HEIGHT,
   parameter int CW     = FB_CW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear_req,
   output logic          clear_busy,
   input  logic          m_req,
   input  logic [CW-1:0] m_x,
   input  logic [CW-1:0] m_y,
   input  logic          m_color,
   output logic          m_gnt,
   input  logic          d_req,
   input  logic [CW-1:0] d_x,
   input  logic [CW-1:0] d_y,
   input  logic          d_color,
   output logic          d_gnt,
   output logic [CW-1:0] fb_x,
   output logic [CW-1:0] fb_y,
   output logic          fb_color,
   output logic          fb_we,
   output logic          drop
);

   fb_state_e     r_state;
   fb_state_e     w_state_next;
   logic          r_last_drawer;   // 1: drawer won the most recent grant
   logic [CW-1:0] r_fb_x;
   logic [CW-1:0] r_fb_y;
   logic          r_fb_color;
   logic          r_fb_we;
   logic          r_drop;

   logic          w_cnt_start;
   logic          w_cnt_adv;
   logic [CW-1:0] w_cx;
   logic [CW-1:0] w_cy;
   logic [CW-1:0] w_nx;
   logic [CW-1:0] w_ny;
   logic          w_last;

   logic [CW-1:0] w_win_x;
   logic [CW-1:0] w_win_y;
   logic          w_win_color;
   logic          w_in_range;

   // The counter always mirrors the clear pixel currently on fb_*; on each
   // sweep step both move to the counter's next position together.
   fb_raster_counter #(
      .CW     (CW),
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT)
   ) u_raster (
      .clk       (clk),
      .reset     (reset),
      .i_start   (w_cnt_start),
      .i_advance (w_cnt_adv),
      .o_cx      (w_cx),
      .o_cy      (w_cy),
      .o_nx      (w_nx),
      .o_ny      (w_ny),
      .o_last    (w_last)
   );

   always_comb begin
      w_state_next = r_state;
      m_gnt        = 1'b0;
      d_gnt        = 1'b0;
      w_cnt_start  = 1'b0;
      w_cnt_adv    = 1'b0;
      case (r_state)
         IDLE: begin
            if (clear_req) begin
               w_state_next = CLEAR;
               w_cnt_start  = 1'b1;
            end else begin
               // On a tie the requester not granted most recently wins.
               m_gnt = m_req && (!d_req || r_last_drawer);
               d_gnt = d_req && (!m_req || !r_last_drawer);
            end
         end
         CLEAR: begin
            if (w_last) begin
               w_state_next = IDLE;
            end else begin
               w_cnt_adv = 1'b1;
            end
         end
         default: w_state_next = IDLE;
      endcase
      if (reset) begin
         m_gnt = 1'b0;
         d_gnt = 1'b0;
      end
   end

   always_comb begin
      w_win_x     = m_gnt ? m_x     : d_x;
      w_win_y     = m_gnt ? m_y     : d_y;
      w_win_color = m_gnt ? m_color : d_color;
      w_in_range  = (w_win_x < CW'(WIDTH)) && (w_win_y < CW'(HEIGHT));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_last_drawer <= 1'b1;
         r_fb_x        <= '0;
         r_fb_y        <= '0;
         r_fb_color    <= 1'b0;
         r_fb_we       <= 1'b0;
         r_drop        <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_fb_we <= 1'b0;
         r_drop  <= 1'b0;
         if (w_cnt_start) begin
            r_fb_x     <= '0;
            r_fb_y     <= '0;
            r_fb_color <= 1'b0;
            r_fb_we    <= 1'b1;
         end else if (w_cnt_adv) begin
            r_fb_x     <= w_nx;
            r_fb_y     <= w_ny;
            r_fb_color <= 1'b0;
            r_fb_we    <= 1'b1;
         end else if (m_gnt || d_gnt) begin
            r_last_drawer <= d_gnt;
            // Out-of-range pixels are consumed but leave the address untouched.
            if (w_in_range) begin
               r_fb_x     <= w_win_x;
               r_fb_y     <= w_win_y;
               r_fb_color <= w_win_color;
               r_fb_we    <= 1'b1;
            end else begin
               r_drop <= 1'b1;
            end
         end
      end
   end

   assign clear_busy = (r_state == CLEAR);
   assign fb_x       = r_fb_x;
   assign fb_y       = r_fb_y;
   assign fb_color   = r_fb_color;
   assign fb_we      = r_fb_we;
   assign drop       = r_drop;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler: directed bench. Instance a uses the full 640x480
// raster for arbitration and range checks; instance b uses a 4x3 raster so
// whole clear sweeps are short.
module tb_fb_write_scheduler;

   localparam int CW = 11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance a (640x480)
   logic          reset_a, clear_req_a, clear_busy_a;
   logic          m_req_a, m_color_a, m_gnt_a, d_req_a, d_color_a, d_gnt_a;
   logic [CW-1:0] m_x_a, m_y_a, d_x_a, d_y_a, fb_x_a, fb_y_a;
   logic          fb_color_a, fb_we_a, drop_a;
   // instance b (4x3)
   logic          reset_b, clear_req_b, clear_busy_b;
   logic          m_req_b, m_color_b, m_gnt_b, d_req_b, d_color_b, d_gnt_b;
   logic [CW-1:0] m_x_b, m_y_b, d_x_b, d_y_b, fb_x_b, fb_y_b;
   logic          fb_color_b, fb_we_b, drop_b;

   fb_write_scheduler #(.WIDTH(640), .HEIGHT(480), .CW(CW)) dut_a (
      .clk(clk), .reset(reset_a), .clear_req(clear_req_a), .clear_busy(clear_busy_a),
      .m_req(m_req_a), .m_x(m_x_a), .m_y(m_y_a), .m_color(m_color_a), .m_gnt(m_gnt_a),
      .d_req(d_req_a), .d_x(d_x_a), .d_y(d_y_a), .d_color(d_color_a), .d_gnt(d_gnt_a),
      .fb_x(fb_x_a), .fb_y(fb_y_a), .fb_color(fb_color_a), .fb_we(fb_we_a), .drop(drop_a)
   );

   fb_write_scheduler #(.WIDTH(4), .HEIGHT(3), .CW(CW)) dut_b (
      .clk(clk), .reset(reset_b), .clear_req(clear_req_b), .clear_busy(clear_busy_b),
      .m_req(m_req_b), .m_x(m_x_b), .m_y(m_y_b), .m_color(m_color_b), .m_gnt(m_gnt_b),
      .d_req(d_req_b), .d_x(d_x_b), .d_y(d_y_b), .d_color(d_color_b), .d_gnt(d_gnt_b),
      .fb_x(fb_x_b), .fb_y(fb_y_b), .fb_color(fb_color_b), .fb_we(fb_we_b), .drop(drop_b)
   );

   int errors = 0;
   int checks = 0;
   logic [2*CW:0] exp_q[$];
   logic [2*CW:0] exp_pix;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_m_a(input logic r, input int x, input int y, input logic c);
      m_req_a = r; m_x_a = CW'(x); m_y_a = CW'(y); m_color_a = c;
   endtask

   task automatic drive_d_a(input logic r, input int x, input int y, input logic c);
      d_req_a = r; d_x_a = CW'(x); d_y_a = CW'(y); d_color_a = c;
   endtask

   task automatic chk_fb_a(input string tag, input logic we, input logic dr,
                           input int x, input int y, input logic c);
      chk({tag, "_we"},    32'(fb_we_a),    32'(we));
      chk({tag, "_drop"},  32'(drop_a),     32'(dr));
      chk({tag, "_x"},     32'(fb_x_a),     32'(x));
      chk({tag, "_y"},     32'(fb_y_a),     32'(y));
      chk({tag, "_color"}, 32'(fb_color_a), 32'(c));
   endtask

   initial begin
      int mi;
      int di;
      reset_a = 1'b1; clear_req_a = 1'b0;
      reset_b = 1'b1; clear_req_b = 1'b0;
      drive_m_a(1'b1, 7, 7, 1'b1);
      drive_d_a(1'b0, 0, 0, 1'b0);
      m_req_b = 1'b0; m_x_b = '0; m_y_b = '0; m_color_b = 1'b0;
      d_req_b = 1'b0; d_x_b = '0; d_y_b = '0; d_color_b = 1'b0;

      // ---- reset ----
      #1;
      chk("rst_m_gnt", 32'(m_gnt_a), 0);
      tick();
      tick();
      chk("rst_m_gnt_held", 32'(m_gnt_a), 0);
      chk_fb_a("rst_a", 1'b0, 1'b0, 0, 0, 1'b0);
      chk("rst_busy_a", 32'(clear_busy_a), 0);
      chk("rst_busy_b", 32'(clear_busy_b), 0);
      chk("rst_we_b", 32'(fb_we_b), 0);
      reset_a = 1'b0;
      reset_b = 1'b0;

      // ---- both requesters held from the first cycle after reset ----
      mi = 0;
      di = 0;
      for (int k = 0; k < 6; k++) begin
         drive_m_a(1'b1, 100 + mi, 200 + mi, mi[0]);
         drive_d_a(1'b1, 300 + di, 50 + di, ~di[0]);
         #1;
         chk("alt_m_gnt", 32'(m_gnt_a), 32'(k % 2 == 0));
         chk("alt_d_gnt", 32'(d_gnt_a), 32'(k % 2 == 1));
         if (k % 2 == 0) begin
            exp_q.push_back({m_x_a, m_y_a, m_color_a});
            mi++;
         end else begin
            exp_q.push_back({d_x_a, d_y_a, d_color_a});
            di++;
         end
         tick();
         exp_pix = exp_q.pop_front();
         chk("alt_we", 32'(fb_we_a), 1);
         chk("alt_pix", 32'({fb_x_a, fb_y_a, fb_color_a}), 32'(exp_pix));
      end
      drive_m_a(1'b0, 0, 0, 1'b0);
      drive_d_a(1'b0, 0, 0, 1'b0);
      tick();
      chk_fb_a("alt_idle", 1'b0, 1'b0, 302, 52, 1'b1);

      // ---- lone mouse pixel ----
      drive_m_a(1'b1, 10, 20, 1'b1);
      #1;
      chk("lone_m_gnt", 32'(m_gnt_a), 1);
      chk("lone_d_gnt", 32'(d_gnt_a), 0);
      tick();
      drive_m_a(1'b0, 0, 0, 1'b0);
      chk_fb_a("lone", 1'b1, 1'b0, 10, 20, 1'b1);

      // ---- out-of-range drawer pixel: dropped, address held ----
      drive_d_a(1'b1, 640, 5, 1'b0);
      #1;
      chk("oor_d_gnt", 32'(d_gnt_a), 1);
      tick();
      drive_d_a(1'b0, 0, 0, 1'b0);
      chk_fb_a("oor_x", 1'b0, 1'b1, 10, 20, 1'b1);
      tick();
      chk("oor_drop_pulse", 32'(drop_a), 0);

      // ---- range boundaries ----
      drive_d_a(1'b1, 639, 479, 1'b0);
      tick();
      chk_fb_a("edge_in", 1'b1, 1'b0, 639, 479, 1'b0);
      drive_d_a(1'b1, 0, 480, 1'b1);
      tick();
      chk_fb_a("oor_y", 1'b0, 1'b1, 639, 479, 1'b0);
      drive_d_a(1'b1, 2047, 0, 1'b1);
      tick();
      drive_d_a(1'b0, 0, 0, 1'b0);
      chk_fb_a("oor_max", 1'b0, 1'b1, 639, 479, 1'b0);

      // ---- clear together with a mouse request (4x3) ----
      clear_req_b = 1'b1;
      m_req_b = 1'b1; m_x_b = CW'(1); m_y_b = CW'(2); m_color_b = 1'b1;
      #1;
      chk("clr_m_gnt_blocked", 32'(m_gnt_b), 0);
      tick();
      clear_req_b = 1'b0;
      for (int k = 0; k < 12; k++) begin
         // a clear request mid-sweep must not restart it
         clear_req_b = (k >= 3 && k <= 5);
         #1;
         chk("clr_busy", 32'(clear_busy_b), 1);
         chk("clr_m_gnt", 32'(m_gnt_b), 0);
         chk("clr_we", 32'(fb_we_b), 1);
         chk("clr_pix", 32'({fb_x_b, fb_y_b, fb_color_b}),
             32'({CW'(k % 4), CW'(k / 4), 1'b0}));
         tick();
         clear_req_b = 1'b0;
      end
      #1;
      chk("clr_end_busy", 32'(clear_busy_b), 0);
      chk("clr_end_we", 32'(fb_we_b), 0);
      chk("clr_end_m_gnt", 32'(m_gnt_b), 1);
      tick();
      m_req_b = 1'b0;
      chk("clr_mouse_we", 32'(fb_we_b), 1);
      chk("clr_mouse_pix", 32'({fb_x_b, fb_y_b, fb_color_b}), 32'({CW'(1), CW'(2), 1'b1}));

      // ---- reset in the middle of a sweep, then restart ----
      clear_req_b = 1'b1;
      tick();
      clear_req_b = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      chk("mid_pix", 32'({fb_x_b, fb_y_b}), 32'({CW'(1), CW'(1)}));
      reset_b = 1'b1;
      tick();
      reset_b = 1'b0;
      chk("mid_rst_we", 32'(fb_we_b), 0);
      chk("mid_rst_busy", 32'(clear_busy_b), 0);
      chk("mid_rst_xy", 32'({fb_x_b, fb_y_b}), 0);
      clear_req_b = 1'b1;
      tick();
      clear_req_b = 1'b0;
      chk("restart_busy", 32'(clear_busy_b), 1);
      chk("restart_we", 32'(fb_we_b), 1);
      chk("restart_xy0", 32'({fb_x_b, fb_y_b}), 0);
      tick();
      chk("restart_xy1", 32'({fb_x_b, fb_y_b}), 32'({CW'(1), CW'(0)}));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
